// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state encoding and ALU operator codes.
package alu_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } arb_state_e;

   localparam logic OpAdd = 1'b0;
   localparam logic OpSub = 1'b1;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins, a tie goes to pri.
module rr_pick2 (
   input  logic valid0,
   input  logic valid1,
   input  logic pri,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = valid0 | valid1;
      gnt_id    = (valid0 & valid1) ? pri : valid1;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for a shared combinational add/sub ALU with two valid/ready clients.
// Defining ALU_ARB_STATS_EN adds grant and overflow counters.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
`ifdef ALU_ARB_STATS_EN
   output logic [7:0]       grant_cnt0,
   output logic [7:0]       grant_cnt1,
   output logic [7:0]       ovf_cnt,
`endif
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_s,
   output logic             rsp_overflow,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_op,
   input  logic [WIDTH-1:0] alu_s,
   input  logic             alu_overflow
);

   arb_state_e       state_q, state_d;
   logic             pri_q, pri_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic             op_q, op_d, ovf_q, ovf_d;
   logic             gnt_valid, gnt_id;
   logic             accept, capture, done;

   rr_pick2 u_pick (
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .pri       (pri_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      state_d = state_q;
      pri_d   = pri_q;
      owner_d = owner_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      s_d     = s_q;
      ovf_d   = ovf_q;
      accept  = 1'b0;
      capture = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (gnt_valid) begin
               accept  = 1'b1;
               owner_d = gnt_id;
               a_d     = gnt_id ? req1_a  : req0_a;
               b_d     = gnt_id ? req1_b  : req0_b;
               op_d    = gnt_id ? req1_op : req0_op;
               state_d = StExec;
            end
         end
         StExec: begin
            capture = 1'b1;
            s_d     = alu_s;
            ovf_d   = alu_overflow;
            state_d = StResp;
         end
         StResp: begin
            done = owner_q ? rsp1_ready : rsp0_ready;
            if (done) begin
               pri_d   = ~owner_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pri_q   <= 1'b0;
         owner_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         s_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pri_q   <= pri_d;
         owner_q <= owner_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         s_q     <= s_d;
         ovf_q   <= ovf_d;
      end
   end

   // Ready is suppressed during reset so nothing is accepted in that cycle.
   always_comb begin
      req0_ready   = ~rst & accept & ~gnt_id;
      req1_ready   = ~rst & accept & gnt_id;
      rsp0_valid   = (state_q == StResp) & ~owner_q;
      rsp1_valid   = (state_q == StResp) & owner_q;
      rsp_s        = s_q;
      rsp_overflow = ovf_q;
      alu_a        = a_q;
      alu_b        = b_q;
      alu_op       = op_q;
   end

`ifdef ALU_ARB_STATS_EN
   logic [7:0] gcnt0_q, gcnt1_q, ocnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         gcnt0_q <= '0;
         gcnt1_q <= '0;
         ocnt_q  <= '0;
      end else begin
         if (accept && !gnt_id)        gcnt0_q <= gcnt0_q + 8'd1;
         if (accept && gnt_id)         gcnt1_q <= gcnt1_q + 8'd1;
         if (capture && alu_overflow)  ocnt_q  <= ocnt_q + 8'd1;
      end
   end

   assign grant_cnt0 = gcnt0_q;
   assign grant_cnt1 = gcnt1_q;
   assign ovf_cnt    = ocnt_q;
`else
   // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a behavioural 4-bit add/sub ALU attached.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         req0_op = 1'b0, req1_op = 1'b0;
   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [W-1:0] rsp_s, alu_a, alu_b, alu_s;
   logic         rsp_overflow, alu_op, alu_overflow;
`ifdef ALU_ARB_STATS_EN
   logic [7:0]   grant_cnt0, grant_cnt1, ovf_cnt;
`endif

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef ALU_ARB_STATS_EN
      .grant_cnt0   (grant_cnt0),
      .grant_cnt1   (grant_cnt1),
      .ovf_cnt      (ovf_cnt),
`endif
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_a       (req0_a),
      .req0_b       (req0_b),
      .req0_op      (req0_op),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_a       (req1_a),
      .req1_b       (req1_b),
      .req1_op      (req1_op),
      .rsp0_valid   (rsp0_valid),
      .rsp0_ready   (rsp0_ready),
      .rsp1_valid   (rsp1_valid),
      .rsp1_ready   (rsp1_ready),
      .rsp_s        (rsp_s),
      .rsp_overflow (rsp_overflow),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_s        (alu_s),
      .alu_overflow (alu_overflow)
   );

   // Stand-in for the combinational ALU4bit.
   always_comb begin
      alu_s        = alu_op ? alu_a - alu_b : alu_a + alu_b;
      alu_overflow = alu_op ? ((alu_a[3] != alu_b[3]) && (alu_s[3] != alu_a[3]))
                            : ((alu_a[3] == alu_b[3]) && (alu_s[3] != alu_a[3]));
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Pending requests, held by the requesters until accepted.
   logic         p_v[2];
   logic [W-1:0] p_a[2], p_b[2];
   logic         p_op[2];

   // Reference model state.
   bit           busy;
   int           owner, acc_cyc, cyc;
   bit           pri;
   logic [W-1:0] m_alu_a, m_alu_b, m_s, x_s;
   logic         m_alu_op, m_ov, x_ov;
   logic [7:0]   m_g0, m_g1, m_oc;

   function automatic int sval(input logic [W-1:0] v);
      return v[W-1] ? int'(v) - (1 << W) : int'(v);
   endfunction

   task automatic model_reset();
      busy = 0; pri = 0;
      m_alu_a = '0; m_alu_b = '0; m_alu_op = 1'b0; m_s = '0; m_ov = 1'b0;
      m_g0 = '0; m_g1 = '0; m_oc = '0;
   endtask

   task automatic push_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic op);
      p_v[id] = 1'b1; p_a[id] = a; p_b[id] = b; p_op[id] = op;
   endtask

   task automatic step(input logic rst_v, input logic [1:0] rr);
      bit   rv, win;
      int   g, res;
      logic er0, er1;
      @(negedge clk);
      rst = rst_v;
      req0_valid = p_v[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_op = p_op[0];
      req1_valid = p_v[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_op = p_op[1];
      rsp0_ready = rr[0]; rsp1_ready = rr[1];
      #1;
      win = !rst_v && !busy && (p_v[0] || p_v[1]);
      g   = (p_v[0] && p_v[1]) ? int'(pri) : (p_v[1] ? 1 : 0);
      er0 = win && g == 0;
      er1 = win && g == 1;
      rv  = busy && (cyc >= acc_cyc + 2);
      check_eq("req0_ready", 8'(req0_ready), 8'(er0));
      check_eq("req1_ready", 8'(req1_ready), 8'(er1));
      check_eq("rsp0_valid", 8'(rsp0_valid), 8'(rv && owner == 0));
      check_eq("rsp1_valid", 8'(rsp1_valid), 8'(rv && owner == 1));
      check_eq("rsp_s", 8'(rsp_s), 8'(m_s));
      check_eq("rsp_overflow", 8'(rsp_overflow), 8'(m_ov));
      check_eq("alu_a", 8'(alu_a), 8'(m_alu_a));
      check_eq("alu_b", 8'(alu_b), 8'(m_alu_b));
      check_eq("alu_op", 8'(alu_op), 8'(m_alu_op));
`ifdef ALU_ARB_STATS_EN
      check_eq("grant_cnt0", grant_cnt0, m_g0);
      check_eq("grant_cnt1", grant_cnt1, m_g1);
      check_eq("ovf_cnt", ovf_cnt, m_oc);
`endif
      if (rst_v) begin
         model_reset();
      end else if (busy && cyc == acc_cyc + 1) begin
         m_s = x_s; m_ov = x_ov;
         if (x_ov) m_oc++;
      end else if (rv && rr[owner]) begin
         busy = 0;
         pri  = (owner == 0);
      end else if (win) begin
         busy = 1; owner = g; acc_cyc = cyc;
         m_alu_a = p_a[g]; m_alu_b = p_b[g]; m_alu_op = p_op[g];
         res  = (p_op[g] == OpSub) ? sval(p_a[g]) - sval(p_b[g]) : sval(p_a[g]) + sval(p_b[g]);
         x_s  = W'(res);
         x_ov = (res > 7) || (res < -8);
         if (g == 0) m_g0++; else m_g1++;
         p_v[g] = 1'b0;
      end
      cyc++;
   endtask

   task automatic run(input int n, input logic [1:0] rr);
      for (int i = 0; i < n; i++) step(1'b0, rr);
   endtask

   initial begin
      int guard;
      p_v[0] = 0; p_v[1] = 0;
      p_a[0] = '0; p_a[1] = '0; p_b[0] = '0; p_b[1] = '0; p_op[0] = 0; p_op[1] = 0;
      cyc = 0; owner = 0; acc_cyc = 0; x_s = '0; x_ov = 0;
      model_reset();
      repeat (2) @(posedge clk);
      step(1'b1, 2'b00);
      run(2, 2'b11);

      push_req(0, 4'd5, 4'd3, OpSub);
      run(4, 2'b11);
      push_req(0, 4'd7, 4'd1, OpAdd);
      run(4, 2'b11);

      push_req(0, 4'd1, 4'd1, OpAdd); push_req(1, 4'd2, 4'd2, OpAdd);
      run(7, 2'b11);
      push_req(0, 4'd3, 4'd4, OpAdd); push_req(1, 4'd6, 4'd2, OpSub);
      run(7, 2'b11);

      // Response stall with a competing requester waiting.
      push_req(0, 4'd9, 4'd4, OpSub);
      run(3, 2'b00);
      push_req(1, 4'd1, 4'd2, OpAdd);
      run(5, 2'b00);
      run(6, 2'b11);

      // Reset landing in the execute cycle.
      push_req(0, 4'd6, 4'd6, OpAdd);
      step(1'b0, 2'b11);
      step(1'b1, 2'b11);
      run(4, 2'b11);

      for (int i = 0; i < 800; i++) begin
         for (int r = 0; r < 2; r++)
            if (!p_v[r] && $urandom_range(2) == 0)
               push_req(r, W'($urandom), W'($urandom), 1'($urandom));
         step(($urandom_range(63) == 0) ? 1'b1 : 1'b0, 2'($urandom));
      end

`ifdef ALU_ARB_STATS_EN
      step(1'b1, 2'b11);
      p_v[1] = 1'b0;
      for (int k = 0; k < 256; k++) begin
         push_req(0, W'($urandom), W'($urandom), 1'($urandom));
         guard = 0;
         while (p_v[0] && guard < 10) begin
            step(1'b0, 2'b11);
            guard++;
         end
         check_eq("accept_timeout", 8'(p_v[0]), 8'd0);
      end
      run(4, 2'b11);
      check_eq("grant_cnt0_wrap", grant_cnt0, 8'd0);
      check_eq("grant_cnt1_hold", grant_cnt1, 8'd0);
`else
      guard = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
